// File: rtl/filter_3x3_ctrl_if.sv
// filter_3x3_ctrl_if: pixel handshake, config and sequencing signals between the stream source and the filter controller
interface filter_3x3_ctrl_if #(
  parameter int CWIDTH = 12
);
  logic [CWIDTH-1:0] cfg_width;
  logic [CWIDTH-1:0] cfg_height;
  logic in_valid;
  logic in_sof;
  logic in_ready;
  logic shift_en;
  logic [CWIDTH-1:0] lb_addr;
  logic [3:0] bypass;
  logic out_valid;
  logic out_sof;
  logic out_eol;
  logic out_eof;
  logic frame_done;
  logic err_sof;
  logic err_cfg;
  modport master (
    output cfg_width, cfg_height, in_valid, in_sof,
    input in_ready, shift_en, lb_addr, bypass, out_valid, out_sof, out_eol, out_eof, frame_done, err_sof, err_cfg
  );
  modport slave (
    input cfg_width, cfg_height, in_valid, in_sof,
    output in_ready, shift_en, lb_addr, bypass, out_valid, out_sof, out_eol, out_eof, frame_done, err_sof, err_cfg
  );
endinterface

// File: rtl/filter_3x3_ctrl.sv
// filter_3x3_ctrl: sequencer for the 3x3 filter datapath: handshake, window coordinates, edge bypass and output markers
module filter_3x3_ctrl #(
  parameter int MAX_W = 2048,
  parameter int CWIDTH = 12,
  parameter int MASK_LAT = 3
) (
  input logic clk,
  input logic rst,
  filter_3x3_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [CWIDTH:0] MW = (CWIDTH+1)'(MAX_W);
  localparam logic [CWIDTH:0] ML = (CWIDTH+1)'(MASK_LAT);
  state_t state;
  logic [CWIDTH-1:0] w, h, ic, ir, cc, cr;
  logic [CWIDTH:0] lag, cnt, w1;
  logic [MASK_LAT:0][3:0] dl;
  logic acc, legal, sof_acc, start, run_px, cvalid, last_c, last_px, c_last, r_last;
  assign bus.in_ready = !rst && (state == IDLE || state == RUN);
  assign acc = bus.in_valid && bus.in_ready;
  assign legal = bus.cfg_width >= CWIDTH'(2) && {1'b0, bus.cfg_width} <= MW && bus.cfg_height >= CWIDTH'(2);
  assign sof_acc = acc && bus.in_sof;
  assign start = sof_acc && legal;
  assign run_px = acc && !bus.in_sof && state == RUN;
  assign bus.shift_en = start || run_px || state == FLUSH;
  assign bus.lb_addr = (bus.shift_en && !start) ? ic : '0;
  assign last_c = ic == w - 1'b1;
  assign last_px = last_c && ir == h - 1'b1;
  assign w1 = {1'b0, w} + 1'b1;
  // the window center trails the input by W+1 shifts; lag saturates once it is reached
  assign cvalid = bus.shift_en && !start && lag == w1;
  assign c_last = cc == w - 1'b1;
  assign r_last = cr == h - 1'b1;
  assign {bus.out_eof, bus.out_eol, bus.out_sof, bus.out_valid} = dl[MASK_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      ic <= '0;
      ir <= '0;
      cc <= '0;
      cr <= '0;
      lag <= '0;
      cnt <= '0;
      dl <= '0;
      bus.bypass <= '0;
      bus.frame_done <= 1'b0;
      bus.err_sof <= 1'b0;
      bus.err_cfg <= 1'b0;
    end else begin
      bus.err_sof <= sof_acc && state == RUN;
      bus.err_cfg <= sof_acc && !legal;
      bus.frame_done <= state == DONE && cnt == ML;
      bus.bypass <= cvalid ? {c_last, cc == '0, r_last, cr == '0} : 4'b0;
      dl <= (sof_acc && state == RUN) ? '0 :
            {dl[MASK_LAT-1:0], cvalid ? {c_last && r_last, c_last, cr == '0 && cc == '0, 1'b1} : 4'b0};
      cnt <= ((state == FLUSH && cnt != {1'b0, w}) || (state == DONE && cnt != ML)) ? cnt + 1'b1 : '0;
      if (start) begin
        w <= bus.cfg_width;
        h <= bus.cfg_height;
        ic <= CWIDTH'(1);
        ir <= '0;
        cc <= '0;
        cr <= '0;
        lag <= (CWIDTH+1)'(1);
      end else if (bus.shift_en) begin
        ic <= last_c ? '0 : ic + 1'b1;
        ir <= last_c ? ir + 1'b1 : ir;
        lag <= (lag == w1) ? lag : lag + 1'b1;
        if (cvalid) begin
          cc <= c_last ? '0 : cc + 1'b1;
          cr <= c_last ? cr + 1'b1 : cr;
        end
      end
      case (state)
        IDLE: state <= start ? RUN : IDLE;
        RUN: state <= sof_acc ? (legal ? RUN : IDLE) : (run_px && last_px) ? FLUSH : RUN;
        FLUSH: state <= (cnt == {1'b0, w}) ? DONE : FLUSH;
        default: state <= (cnt == ML) ? IDLE : DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_filter_3x3_ctrl.sv
// tb_filter_3x3_ctrl: directed cycle-by-cycle checks of the filter controller on 4x3 frames
module tb_filter_3x3_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  filter_3x3_ctrl_if #(.CWIDTH(12)) bus ();
  filter_3x3_ctrl #(.MAX_W(2048), .CWIDTH(12), .MASK_LAT(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  // {in_ready, shift_en, out_valid, out_sof, out_eol, out_eof, frame_done, err_sof, err_cfg, bypass, lb_addr}
  logic [24:0] pack;
  logic [24:0] obs [40];
  logic [24:0] exp_v [40];
  logic v [40];
  logic s [40];
  logic r [40];
  logic [3:0] bt [12];
  int n_assert = 0;
  int n_fail = 0;
  assign pack = {bus.in_ready, bus.shift_en, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof,
                 bus.frame_done, bus.err_sof, bus.err_cfg, bus.bypass, bus.lb_addr};
  task automatic clr(input int lo, input int hi);
    for (int c = 0; c < 40; c++) begin
      exp_v[c] = (c >= lo && c <= hi) ? 25'd0 : 25'h1000000;
      v[c] = 1'b0;
      s[c] = 1'b0;
      r[c] = 1'b0;
    end
  endtask
  task automatic add_shift(input int c, input int k, input bit outs);
    exp_v[c][23] = 1'b1;
    exp_v[c][11:0] = 12'(k % 4);
    if (k >= 5) begin
      exp_v[c+1][15:12] = bt[k-5];
      if (outs) exp_v[c+4][22:19] = {1'b1, k == 5, (k - 5) % 4 == 3, k == 16};
    end
  endtask
  task automatic frame_a();
    clr(12, 20);
    for (int c = 0; c < 12; c++) v[c] = 1'b1;
    s[0] = 1'b1;
    for (int k = 0; k < 17; k++) add_shift(k, k, 1'b1);
    exp_v[21][18] = 1'b1;
  endtask
  task automatic run(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rst = r[c];
      bus.in_valid = v[c];
      bus.in_sof = s[c];
      #1 obs[c] = pack;
    end
    for (int c = 0; c < n; c++) begin
      n_assert++;
      assert (obs[c] === exp_v[c]) else begin
        n_fail++;
        $error("FAIL %s cycle %0d observed=%h expected=%h", tag, c, obs[c], exp_v[c]);
      end
    end
  endtask
  initial begin
    bt = '{4'b0101, 4'b0001, 4'b0001, 4'b1001, 4'b0100, 4'b0000,
           4'b0000, 4'b1000, 4'b0110, 4'b0010, 4'b0010, 4'b1010};
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.cfg_width = 12'd4;
    bus.cfg_height = 12'd3;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    assert (pack === 25'd0) else begin
      n_fail++;
      $error("FAIL reset observed=%h expected=%h", pack, 25'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_assert++;
    assert (pack === 25'h1000000) else begin
      n_fail++;
      $error("FAIL ready_after_reset observed=%h expected=%h", pack, 25'h1000000);
    end
    frame_a();
    run("frame", 24);
    clr(23, 31);
    for (int c = 0; c <= 22; c += 2) v[c] = 1'b1;
    s[0] = 1'b1;
    for (int k = 0; k < 12; k++) add_shift(2 * k, k, 1'b1);
    for (int k = 12; k < 17; k++) add_shift(11 + k, k, 1'b1);
    exp_v[32][18] = 1'b1;
    run("gaps", 34);
    clr(18, 26);
    for (int c = 0; c <= 17; c++) v[c] = 1'b1;
    s[0] = 1'b1;
    s[6] = 1'b1;
    for (int k = 0; k < 6; k++) add_shift(k, k, 1'b0);
    for (int k = 0; k < 17; k++) add_shift(6 + k, k, 1'b1);
    exp_v[7][17] = 1'b1;
    exp_v[27][18] = 1'b1;
    run("resof", 30);
    bus.cfg_width = 12'd1;
    clr(1, 0);
    for (int c = 0; c < 4; c++) v[c] = 1'b1;
    s[0] = 1'b1;
    exp_v[1][16] = 1'b1;
    run("badcfg", 6);
    bus.cfg_width = 12'd4;
    frame_a();
    r[14] = 1'b1;
    r[15] = 1'b1;
    for (int c = 15; c < 25; c++) exp_v[c] = (c == 15) ? 25'd0 : 25'h1000000;
    run("rst_flush", 25);
    frame_a();
    run("after_rst", 24);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
